mc_control_fsm: RTL

- Multicycle control sequencer that sits directly upstream of the MIPS datapath.
- Consumes the datapath's opcode, func and Zero outputs; drives ALUOp, PCSrc, RegDst, ALUSrc, MemToReg, regWrite, MemWrite and MemRead.
- Adds the multicycle strobes PCWrite, IRWrite, IorD and pc_alu, so one instruction spans 3-5 clocks.
- Also provides an illegal-instruction trap and a retired-instruction counter.

---
 rtl/mc_control_fsm.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multicycle MIPS control sequencer with illegal-instruction trap
//            and retired-instruction counter. Optional macro CTRL_MEM_WAIT_EN
//            adds a mem_ready handshake on FETCH, MEMRD and MEMWR.
// Revision : 1.0
// ============================================================================
module mc_control_fsm #(
    parameter int         CNT_W    = 16,
    parameter logic [5:0] RTYPE_OP = 6'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             Zero,
`ifdef CTRL_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic [2:0]       ALUOp,
    output logic             PCSrc,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             regWrite,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             pc_alu,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0]       c_OP_LW   = 6'h23;
    localparam logic [5:0]       c_OP_SW   = 6'h2B;
    localparam logic [5:0]       c_OP_BEQ  = 6'h04;
    localparam logic [5:0]       c_OP_ADDI = 6'h08;
    localparam logic [2:0]       c_ALU_ADD = 3'b010;
    localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_ERROR  = 4'd15
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [14:0]      r_outs;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       w_func_alu;
    logic             w_func_ok;
    logic             w_rdy;
    logic             w_retire;

`ifdef CTRL_MEM_WAIT_EN
    assign w_rdy = mem_ready;
`else
    assign w_rdy = 1'b1;
`endif

    always_comb begin
        w_func_ok  = 1'b1;
        w_func_alu = c_ALU_ADD;
        case (func)
            6'h20:   w_func_alu = 3'b010;
            6'h22:   w_func_alu = 3'b110;
            6'h24:   w_func_alu = 3'b000;
            6'h25:   w_func_alu = 3'b001;
            6'h2A:   w_func_alu = 3'b111;
            default: w_func_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_ERROR;
        case (r_state)
            S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == c_OP_LW || opcode == c_OP_SW) w_next = S_MEMADR;
                else if (opcode == RTYPE_OP)  w_next = w_func_ok ? S_EXEC : S_ERROR;
                else if (opcode == c_OP_BEQ)  w_next = S_BRANCH;
                else if (opcode == c_OP_ADDI) w_next = S_ADDIEX;
                else                          w_next = S_ERROR;
            end
            S_MEMADR: w_next = (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = w_rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            default:  w_next = S_ERROR;
        endcase
    end

    // Any entry into FETCH from another state completes an instruction.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

    // Output vector {ALUOp, PCSrc, RegDst, ALUSrc, MemToReg, regWrite,
    // MemWrite, MemRead, PCWrite, IRWrite, IorD, pc_alu, illegal}.
    function automatic logic [14:0] f_outs(input state_t s, input logic [2:0] falu);
        logic [2:0]  alu;
        logic [11:0] b;
        alu = c_ALU_ADD;
        b   = 12'd0;
        case (s)
            S_FETCH:  b = 12'b0000_0011_1010;
            S_MEMADR: b = 12'b0010_0000_0000;
            S_MEMRD:  b = 12'b0010_0010_0100;
            S_MEMWB:  b = 12'b0001_1000_0000;
            S_MEMWR:  b = 12'b0010_0100_0100;
            S_EXEC:   alu = falu;
            S_ALUWB:  begin alu = falu; b = 12'b0100_1000_0000; end
            S_BRANCH: begin alu = 3'b110; b = 12'b1000_0000_0000; end
            S_ADDIEX: b = 12'b0010_0000_0000;
            S_ADDIWB: b = 12'b0010_1000_0000;
            S_ERROR:  b = 12'b0000_0000_0001;
            default:  b = 12'd0;
        endcase
        return {alu, b};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_outs  <= f_outs(S_FETCH, c_ALU_ADD);
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_outs  <= f_outs(w_next, w_func_alu);
            if (w_retire)
                r_count <= r_count + c_ONE;
        end
    end

    // Strobes are forced low while reset is held so they drop without a clock edge.
    assign ALUOp       = reset ? c_ALU_ADD : ((r_state == S_EXEC) ? w_func_alu : r_outs[14:12]);
    assign PCSrc       = r_outs[11] & ~reset;
    assign RegDst      = r_outs[10] & ~reset;
    assign ALUSrc      = r_outs[9]  & ~reset;
    assign MemToReg    = r_outs[8]  & ~reset;
    assign regWrite    = r_outs[7]  & ~reset;
    assign MemWrite    = r_outs[6]  & w_rdy & ~reset;
    assign MemRead     = r_outs[5]  & ~reset;
    assign PCWrite     = ~reset & ((r_outs[4] & w_rdy) | ((r_state == S_BRANCH) & Zero));
    assign IRWrite     = r_outs[3]  & w_rdy & ~reset;
    assign IorD        = r_outs[2]  & ~reset;
    assign pc_alu      = r_outs[1]  & ~reset;
    assign illegal     = r_outs[0];
    assign state       = r_state;
    assign instr_count = r_count;

endmodule
`default_nettype wire
